ddfs_fir_top: RTL and testbench

DDFS_FIR_TOP -- requirements
Module: ddfs_fir_top

---
 rtl/ddfs_fir_top.sv | 100 ++++++++++
 tb/tb_ddfs_fir_top.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/ddfs_fir_top.sv
// ddfs_fir_top: direct digital frequency synthesizer with envelope scaling
// and an optional 4-tap binomial smoothing FIR on the output.
//
// Phase accumulator -> sine ROM (registered read) -> envelope multiply ->
// [FIR t0..t3, taps 1/3/3/1 scaled by 1/8] -> waveform_o.
//
// Build option: define DDFS_FIR_EN to compile in the FIR stage. Without it
// the product register drives waveform_o directly.
module ddfs_fir_top #(
    parameter int PHASE_WIDTH = 32,
    parameter int ADDR_WIDTH  = 10
) (
    input  logic                      clk_in,
    input  logic                      reset,
    input  logic [PHASE_WIDTH-1:0]    fcw_c_i,
    input  logic [PHASE_WIDTH-1:0]    fcw_off_i,
    input  logic [PHASE_WIDTH-1:0]    pha_off_i,
    input  logic signed [15:0]        env_i,
    output logic signed [31:0]        waveform_o
);

    localparam int    ROM_DEPTH = 2 ** ADDR_WIDTH;
    localparam real   TWO_PI    = 6.283185307179586;

    logic [PHASE_WIDTH-1:0]   phase;
    logic [ADDR_WIDTH-1:0]    rom_addr;
    logic signed [15:0]       sine_q;
    logic signed [31:0]       prod_q;

    // Quarter-wave symmetry is not exploited; the full cycle is tabulated so
    // the address path stays a plain slice of the phase.
    // NOTE: the ROM is a constant table, not state, so it has no reset.
    logic signed [15:0]       rom [ROM_DEPTH];

    for (genvar k = 0; k < ROM_DEPTH; k++) begin : g_rom
        localparam real RAW = 32767.0 * $sin(TWO_PI * k / ROM_DEPTH);
        localparam int  VAL = (RAW >= 0.0) ? $rtoi(RAW + 0.5) : $rtoi(RAW - 0.5);
        assign rom[k] = 16'(VAL);
    end

    // ROM address: upper bits of the offset phase, taken from the current accumulator value.
    assign rom_addr = ADDR_WIDTH'((phase + pha_off_i) >> (PHASE_WIDTH - ADDR_WIDTH));

    // Phase accumulation, sine lookup and envelope scaling; wraps silently.
    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples the value its predecessor held before this edge.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            phase  <= '0;
            sine_q <= '0;
            prod_q <= '0;
        end else begin
            phase  <= phase + fcw_c_i + fcw_off_i;
            sine_q <= rom[rom_addr];
            prod_q <= sine_q * env_i;
        end
    end

`ifdef DDFS_FIR_EN
    logic signed [31:0] t0, t1, t2, t3;
    logic signed [34:0] t0_x, t1_x, t2_x, t3_x;
    logic signed [34:0] fir_sum;

    // Sign-extend taps into the 35-bit accumulation width before summing.
    assign t0_x = t0;
    assign t1_x = t1;
    assign t2_x = t2;
    assign t3_x = t3;

    // Binomial taps 1,3,3,1 sum to 8, so the >>>3 gives unity DC gain.
    assign fir_sum = t0_x + 35'sd3 * t1_x + 35'sd3 * t2_x + t3_x;

    // Delay line and filtered output register.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            t0         <= '0;
            t1         <= '0;
            t2         <= '0;
            t3         <= '0;
            waveform_o <= '0;
        end else begin
            t0         <= prod_q;
            t1         <= t0;
            t2         <= t1;
            t3         <= t2;
            waveform_o <= 32'(fir_sum >>> 3);
        end
    end
`else
    // Unfiltered build: the product is forwarded one register later.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            waveform_o <= '0;
        end else begin
            waveform_o <= prod_q;
        end
    end
`endif

endmodule

// File: tb/tb_ddfs_fir_top.sv
// tb_ddfs_fir_top: randomized and directed stimulus for ddfs_fir_top,
// compared every cycle against a sample-history model of the synthesizer.
module tb_ddfs_fir_top;

    localparam int  PW   = 32;
    localparam int  AW   = 10;
    localparam int  N    = 1 << AW;
    localparam longint PEAK = 64'd536854528;

    logic               clk_in = 1'b0;
    logic               reset;
    logic [PW-1:0]      fcw_c_i, fcw_off_i, pha_off_i;
    logic signed [15:0] env_i;
    logic signed [31:0] waveform_o;

    ddfs_fir_top #(.PHASE_WIDTH(PW), .ADDR_WIDTH(AW)) dut (
        .clk_in     (clk_in),
        .reset      (reset),
        .fcw_c_i    (fcw_c_i),
        .fcw_off_i  (fcw_off_i),
        .pha_off_i  (pha_off_i),
        .env_i      (env_i),
        .waveform_o (waveform_o)
    );

    always #5 clk_in = ~clk_in;

    int n_vec = 0;
    int n_bad = 0;

    // Reference: ideal sine table, phase as a wrapping integer, and a history
    // of envelope products (hist[k] = product formed k edges ago).
    longint      sine_tab [N];
    logic [PW-1:0] m_phase;
    longint      m_sine;
    longint      hist [6];
    longint      exp_w;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    function automatic longint fir_out();
`ifdef DDFS_FIR_EN
        return (hist[2] + 3 * hist[3] + 3 * hist[4] + hist[5]) >>> 3;
`else
        return hist[1];
`endif
    endfunction

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_edge();
        longint new_m;
        int     idx;
        if (reset) begin
            m_phase = '0;
            m_sine  = 0;
            for (int k = 0; k < 6; k++) hist[k] = 0;
        end else begin
            new_m   = m_sine * longint'(env_i);
            idx     = int'((m_phase + pha_off_i) / (64'd1 << (PW - AW)));
            m_sine  = sine_tab[idx];
            m_phase = m_phase + fcw_c_i + fcw_off_i;
            for (int k = 5; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = new_m;
        end
        exp_w = fir_out();
    endtask

    task automatic step(input string tag);
        @(posedge clk_in);
        model_edge();
        @(negedge clk_in);
        check(tag, waveform_o, exp_w);
    endtask

    task automatic set_in(input logic [PW-1:0] c, input logic [PW-1:0] o,
                          input logic [PW-1:0] ph, input logic [15:0] e);
        fcw_c_i   = c;
        fcw_off_i = o;
        pha_off_i = ph;
        env_i     = e;
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        for (int i = 0; i < cycles; i++) step("reset");
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        longint hi, lo, fcw, v;
        real r;
        for (int k = 0; k < N; k++) begin
            r = 32767.0 * $sin(2.0 * 3.141592653589793 * k / N);
            sine_tab[k] = (r >= 0.0) ? longint'($rtoi(r + 0.5)) : longint'($rtoi(r - 0.5));
        end
        m_phase = '0;
        m_sine  = 0;
        for (int k = 0; k < 6; k++) hist[k] = 0;

        // Reset held with busy inputs: output must stay 0, also one cycle after.
        reset = 1'b1;
        set_in(32'h1234_5678, 32'h0F0F_0F0F, 32'h4000_0000, 16'h4000);
        do_reset(4);
        step("post_reset");
        check("post_reset_zero", waveform_o, 64'd0);

        // Constant quarter-phase, positive envelope: unity-gain settle to the peak product.
        set_in(32'd0, 32'd0, 32'h4000_0000, 16'h4000);
        do_reset(2);
        for (int i = 0; i < 10; i++) step("dc_pos");
        check("dc_pos_level", waveform_o, PEAK);

        // Same with negative envelope: inverted.
        set_in(32'd0, 32'd0, 32'h4000_0000, 16'hC000);
        do_reset(2);
        for (int i = 0; i < 10; i++) step("dc_neg");
        check("dc_neg_level", waveform_o, -PEAK);

        // Envelope zero flushes the pipeline to 0.
        env_i = 16'h0000;
        for (int i = 0; i < 8; i++) step("env_zero");
        check("env_zero_level", waveform_o, 64'd0);

        // One address step per cycle: full period over 1024 cycles.
        set_in(32'd1 << 22, 32'd0, 32'd0, 16'h4000);
        do_reset(2);
        hi = 0;
        lo = 0;
        for (int i = 0; i < 1100; i++) begin
            step("period");
            v = longint'(waveform_o);
            if (v > hi) hi = v;
            if (v < lo) lo = v;
        end
        check("period_peak", 64'(hi >= 64'sd536000000 && hi <= PEAK), 64'd1);
        check("period_trough", 64'(lo <= -64'sd536000000 && lo >= -PEAK), 64'd1);

        // fcw_c + fcw_off wraps to 1; phase offset puts an address boundary 5 steps away.
        set_in(32'hFFFF_FFFF, 32'd2, (32'd1 << 22) - 32'd5, 16'h4000);
        do_reset(2);
        for (int i = 0; i < 16; i++) step("fcw_wrap");
        check("fcw_wrap_level", waveform_o, sine_tab[1] * 16384);

        // Frequency sweep: no unknowns, amplitude bounded.
        do_reset(2);
        for (int s = 0; s < 25; s++) begin
            fcw = 64'd13743895 + (64'd214748364 - 64'd13743895) * s / 24;
            set_in(PW'(fcw), 32'd0, 32'd0, 16'h4000);
            for (int i = 0; i < 20; i++) step("sweep");
            check("sweep_known", 64'($isunknown(waveform_o)), 64'd0);
            v = longint'(waveform_o);
            check("sweep_bound", 64'(v <= PEAK && v >= -PEAK), 64'd1);
        end

        // Random control changes every cycle, with a reset dropped in mid-stream.
        for (int i = 0; i < 400; i++) begin
            set_in($urandom, $urandom, $urandom, 16'($urandom));
            reset = (i >= 200 && i < 202);
            step("random");
        end
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
